// File: rtl/wb_commit_buffer.sv
// rtl/wb_commit_buffer.sv - in-order writeback commit FIFO with RF write port, forwarding and trace.
// Optional macro WB_TRACE_EN: store pc per entry and drive the trace_* stream.
module wb_commit_buffer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_WIDTH-1:0]      in_rd,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic [31:0]                in_pc,
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata,
  input  logic [ADDR_WIDTH-1:0]      rs1_addr,
  input  logic [ADDR_WIDTH-1:0]      rs2_addr,
  output logic                       rs1_hit,
  output logic [DATA_WIDTH-1:0]      rs1_fwd,
  output logic                       rs2_hit,
  output logic [DATA_WIDTH-1:0]      rs2_fwd,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       trace_valid,
  output logic [31:0]                trace_pc,
  output logic [ADDR_WIDTH-1:0]      trace_rd,
  output logic [DATA_WIDTH-1:0]      trace_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [ADDR_WIDTH-1:0] mem_rd   [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic                  push;
  logic                  pop;

  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = (count != '0);

  always_ff @(posedge clock) begin
    if (push) begin
      mem_rd[wr_ptr]   <= in_rd;
      mem_data[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // x0 results still drain through the output stage but never assert the write enable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (pop) begin
      rf_wen   <= (mem_rd[rd_ptr] != '0);
      rf_waddr <= mem_rd[rd_ptr];
      rf_wdata <= mem_data[rd_ptr];
    end else begin
      rf_wen <= 1'b0;
    end
  end

`ifdef WB_TRACE_EN
  logic [31:0] mem_pc [DEPTH];

  always_ff @(posedge clock) begin
    if (push) mem_pc[wr_ptr] <= in_pc;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_rd    <= '0;
      trace_data  <= '0;
    end else if (pop) begin
      trace_valid <= 1'b1;
      trace_pc    <= mem_pc[rd_ptr];
      trace_rd    <= mem_rd[rd_ptr];
      trace_data  <= mem_data[rd_ptr];
    end else begin
      trace_valid <= 1'b0;
    end
  end
`else
  logic unused_pc;
  assign unused_pc   = ^in_pc;
  assign trace_valid = 1'b0;
  assign trace_pc    = '0;
  assign trace_rd    = '0;
  assign trace_data  = '0;
`endif

  // Walk oldest to newest so the newest matching entry wins; output stage is lowest priority.
  function automatic logic [DATA_WIDTH:0] lookup(input logic [ADDR_WIDTH-1:0] addr);
    logic                  hit;
    logic [DATA_WIDTH-1:0] val;
    logic [PW-1:0]         idx;
    hit = 1'b0;
    val = '0;
    idx = '0;
    if (addr != '0) begin
      if (rf_wen && (rf_waddr == addr)) begin
        hit = 1'b1;
        val = rf_wdata;
      end
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr + PW'(k);
        if ((CW'(k) < count) && (mem_rd[idx] == addr)) begin
          hit = 1'b1;
          val = mem_data[idx];
        end
      end
    end
    return {hit, val};
  endfunction

  always_comb begin
    {rs1_hit, rs1_fwd} = lookup(rs1_addr);
    {rs2_hit, rs2_fwd} = lookup(rs2_addr);
  end

endmodule
